// File: rtl/time_up_counter.sv
// MM:SS up-counter with BCD digits, a run/pause/done control FSM and a
// configurable stop limit; reset and restart preload the count from init inputs.
`timescale 1ns/1ps
module time_up_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] min_ten_init,
    input  logic [3:0] min_one_init,
    input  logic [3:0] sec_ten_init,
    input  logic [3:0] sec_one_init,
    input  logic [3:0] limit_min_ten,
    input  logic [3:0] limit_min_one,
    input  logic [3:0] limit_sec_ten,
    input  logic [3:0] limit_sec_one,
    input  logic       start,
    input  logic       pause,
    input  logic       increase,
    output logic [3:0] min_ten,
    output logic [3:0] min_one,
    output logic [3:0] sec_ten,
    output logic [3:0] sec_one,
    output logic       total_carry,
    output logic       done,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] min_ten_q, min_ten_d;
    logic [3:0] min_one_q, min_one_d;
    logic [3:0] sec_ten_q, sec_ten_d;
    logic [3:0] sec_one_q, sec_one_d;
    logic       carry_q, carry_d;
    logic       done_q, done_d;

    logic       so_wrap, st_wrap, mo_wrap, mt_wrap, all_wrap;
    logic [3:0] inc_mt, inc_mo, inc_st, inc_so;
    logic       limit_hit;

    // Out-of-range digits (>= the wrap point) are treated as wrapping.
    assign so_wrap  = (sec_one_q >= 4'd9);
    assign st_wrap  = (sec_ten_q >= 4'd5);
    assign mo_wrap  = (min_one_q >= 4'd9);
    assign mt_wrap  = (min_ten_q >= 4'd5);
    assign all_wrap = so_wrap && st_wrap && mo_wrap && mt_wrap;

    always_comb begin
        inc_so = so_wrap ? 4'd0 : sec_one_q + 4'd1;
        inc_st = sec_ten_q;
        inc_mo = min_one_q;
        inc_mt = min_ten_q;
        if (so_wrap) begin
            inc_st = st_wrap ? 4'd0 : sec_ten_q + 4'd1;
        end
        if (so_wrap && st_wrap) begin
            inc_mo = mo_wrap ? 4'd0 : min_one_q + 4'd1;
        end
        if (so_wrap && st_wrap && mo_wrap) begin
            inc_mt = mt_wrap ? 4'd0 : min_ten_q + 4'd1;
        end
    end

    // Only the post-increment value can end a run.
    assign limit_hit = ({inc_mt, inc_mo, inc_st, inc_so} ==
                        {limit_min_ten, limit_min_one, limit_sec_ten, limit_sec_one});

    always_comb begin
        state_d   = state_q;
        min_ten_d = min_ten_q;
        min_one_d = min_one_q;
        sec_ten_d = sec_ten_q;
        sec_one_d = sec_one_q;
        carry_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !pause) state_d = StRun;
            end
            StRun: begin
                if (pause) begin
                    state_d = StPause;
                end else if (increase) begin
                    min_ten_d = inc_mt;
                    min_one_d = inc_mo;
                    sec_ten_d = inc_st;
                    sec_one_d = inc_so;
                    carry_d   = all_wrap;
                    if (limit_hit) state_d = StDone;
                end
            end
            StPause: begin
                if (start && !pause) state_d = StRun;
            end
            StDone: begin
                if (start) begin
                    min_ten_d = min_ten_init;
                    min_one_d = min_one_init;
                    sec_ten_d = sec_ten_init;
                    sec_one_d = sec_one_init;
                    state_d   = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            min_ten_q <= min_ten_init;
            min_one_q <= min_one_init;
            sec_ten_q <= sec_ten_init;
            sec_one_q <= sec_one_init;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_ten_q <= min_ten_d;
            min_one_q <= min_one_d;
            sec_ten_q <= sec_ten_d;
            sec_one_q <= sec_one_d;
            carry_q   <= carry_d;
            done_q    <= done_d;
        end
    end

    assign min_ten     = min_ten_q;
    assign min_one     = min_one_q;
    assign sec_ten     = sec_ten_q;
    assign sec_one     = sec_one_q;
    assign total_carry = carry_q;
    assign done        = done_q;
    assign state       = state_q;

endmodule

// File: tb/tb_time_up_counter.sv
// Directed bench for time_up_counter: a vector table for the basic run/pause/done
// flow plus hand-written sequences for wrap, limit, restart and async reset cases.
`timescale 1ns/1ps
module tb_time_up_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] init = 16'h0000;
    logic [15:0] limit = 16'h0005;
    logic        start = 1'b0, pause = 1'b0, increase = 1'b0;
    logic [3:0]  min_ten, min_one, sec_ten, sec_one;
    logic        total_carry, done;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    time_up_counter dut (
        .clk          (clk),
        .reset        (reset),
        .min_ten_init (init[15:12]),
        .min_one_init (init[11:8]),
        .sec_ten_init (init[7:4]),
        .sec_one_init (init[3:0]),
        .limit_min_ten(limit[15:12]),
        .limit_min_one(limit[11:8]),
        .limit_sec_ten(limit[7:4]),
        .limit_sec_one(limit[3:0]),
        .start        (start),
        .pause        (pause),
        .increase     (increase),
        .min_ten      (min_ten),
        .min_one      (min_one),
        .sec_ten      (sec_ten),
        .sec_one      (sec_one),
        .total_carry  (total_carry),
        .done         (done),
        .state        (state)
    );

    typedef struct {
        logic        s, p, i;
        logic [15:0] init, limit, cnt;
        logic [1:0]  st;
        logic        dn, cy;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic s, logic p, logic i, logic [15:0] in, logic [15:0] lm,
                                logic [15:0] cnt, logic [1:0] st, logic dn, logic cy);
        vec_t v;
        v.s = s; v.p = p; v.i = i; v.init = in; v.limit = lm;
        v.cnt = cnt; v.st = st; v.dn = dn; v.cy = cy;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] cnt, logic [1:0] st, logic dn, logic cy);
        logic [15:0] act;
        act = {min_ten, min_one, sec_ten, sec_one};
        checks++;
        if (act !== cnt || state !== st || done !== dn || total_carry !== cy) begin
            errors++;
            $display("FAIL %s: got cnt=%h state=%0d done=%b carry=%b, want cnt=%h state=%0d done=%b carry=%b",
                     name, act, state, done, total_carry, cnt, st, dn, cy);
        end
    endtask

    task automatic step(logic s, logic p, logic i);
        @(negedge clk);
        start = s; pause = p; increase = i;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(logic [15:0] in, logic [15:0] lm);
        @(negedge clk);
        init = in; limit = lm; start = 0; pause = 0; increase = 0;
        #1 reset = 1'b0;
        #1 check("reset", in, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0000, 2'd0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 16'h0000, 16'h0005, 16'h0000, 2'd0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 16'h0000, 16'h0005, 16'h0000, 2'd1, 0, 0);
        vecs[3]  = mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0001, 2'd1, 0, 0);
        vecs[4]  = mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0002, 2'd1, 0, 0);
        vecs[5]  = mk(0, 1, 1, 16'h0000, 16'h0005, 16'h0002, 2'd2, 0, 0);
        vecs[6]  = mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0002, 2'd2, 0, 0);
        vecs[7]  = mk(1, 1, 0, 16'h0000, 16'h0005, 16'h0002, 2'd2, 0, 0);
        vecs[8]  = mk(1, 0, 1, 16'h0000, 16'h0005, 16'h0002, 2'd1, 0, 0);
        vecs[9]  = mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0003, 2'd1, 0, 0);
        vecs[10] = mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0004, 2'd1, 0, 0);
        vecs[11] = mk(0, 0, 0, 16'h0000, 16'h0005, 16'h0004, 2'd1, 0, 0);
        vecs[12] = mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0005, 2'd3, 1, 0);
        vecs[13] = mk(0, 0, 1, 16'h0000, 16'h0005, 16'h0005, 2'd3, 1, 0);
        vecs[14] = mk(0, 1, 1, 16'h0000, 16'h0005, 16'h0005, 2'd3, 1, 0);
        vecs[15] = mk(1, 0, 0, 16'h0100, 16'h0005, 16'h0100, 2'd1, 0, 0);
        vecs[16] = mk(0, 0, 1, 16'h0100, 16'h0005, 16'h0101, 2'd1, 0, 0);

        do_reset(16'h0000, 16'h0005);
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            init = vecs[k].init; limit = vecs[k].limit;
            start = vecs[k].s; pause = vecs[k].p; increase = vecs[k].i;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", k), vecs[k].cnt, vecs[k].st, vecs[k].dn, vecs[k].cy);
        end

        // Full wrap 59:59 -> 00:00 with a carry pulse
        do_reset(16'h5958, 16'h0010);
        step(1, 0, 0); check("wrap_start", 16'h5958, 2'd1, 0, 0);
        step(0, 0, 1); check("wrap_5959", 16'h5959, 2'd1, 0, 0);
        step(0, 0, 1); check("wrap_0000", 16'h0000, 2'd1, 0, 1);
        step(0, 0, 0); check("wrap_carry_off", 16'h0000, 2'd1, 0, 0);

        // Pause with increase held, then resume
        do_reset(16'h0009, 16'h0500);
        step(1, 0, 0); check("pz_run", 16'h0009, 2'd1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 1); check($sformatf("pz_hold%0d", k), 16'h0009, 2'd2, 0, 0);
        end
        step(1, 0, 1); check("pz_resume", 16'h0009, 2'd1, 0, 0);
        step(0, 0, 1); check("pz_tick", 16'h0010, 2'd1, 0, 0);

        // Count equal to limit at entry does not end the run; live limit change
        do_reset(16'h0010, 16'h0010);
        step(1, 0, 0); check("lim_entry", 16'h0010, 2'd1, 0, 0);
        step(0, 0, 1); check("lim_pass", 16'h0011, 2'd1, 0, 0);
        @(negedge clk); limit = 16'h0012;
        step(0, 0, 1); check("lim_live", 16'h0012, 2'd3, 1, 0);
        step(0, 0, 0); check("lim_done_hold", 16'h0012, 2'd3, 1, 0);

        // Out-of-range digits wrap: 00:6A -> 01:00
        do_reset(16'h006A, 16'h5000);
        step(1, 0, 0);
        step(0, 0, 1); check("oor_wrap", 16'h0100, 2'd1, 0, 0);

        // Limit 00:00 reached by wrap
        do_reset(16'h5959, 16'h0000);
        step(1, 0, 0);
        step(0, 0, 1); check("lim_zero", 16'h0000, 2'd3, 1, 1);
        step(0, 0, 0); check("lim_zero_after", 16'h0000, 2'd3, 1, 0);

        // Async reset mid-run between edges
        do_reset(16'h1233, 16'h5000);
        step(1, 0, 0);
        step(0, 0, 1); check("ar_1234", 16'h1234, 2'd1, 0, 0);
        @(negedge clk);
        increase = 0;
        init = 16'h0207;
        #1 reset = 1'b0;
        #1 check("ar_async", 16'h0207, 2'd0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step(0, 0, 1); check("ar_idle", 16'h0207, 2'd0, 0, 0);
        step(1, 0, 0); check("ar_restart", 16'h0207, 2'd1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_up_counter.md
TIME_UP_COUNTER -- requirements
Module: time_up_counter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 min_ten_init, min_one_init, sec_ten_init, sec_one_init  input  4 each  BCD preset loaded on reset and on restart.
REQ-005 limit_min_ten, limit_min_one, limit_sec_ten, limit_sec_one  input  4 each  BCD target value that ends a run.
REQ-006 start  input  1  level-sampled run request.
REQ-007 pause  input  1  level-sampled hold request.
REQ-008 increase  input  1  one-cycle tick; each sampled high adds one second.
REQ-009 min_ten, min_one, sec_ten, sec_one  output  4 each  registered BCD count MM:SS.
REQ-010 total_carry  output  1  registered one-cycle pulse on 59:59 to 00:00 wrap.
REQ-011 done  output  1  registered; high while the FSM is in DONE.
REQ-012 state  output  2  registered FSM encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-013 Counting SHALL occur only on an edge where state==RUN, pause==0 and increase==1; otherwise all four digits SHALL hold.
REQ-014 sec_one SHALL increment; at 9 (or any value >=9) it SHALL wrap to 0 and carry into sec_ten.
REQ-015 sec_ten SHALL take the carry; at 5 (or >=5) it SHALL wrap to 0 and carry into min_one.
REQ-016 min_one and min_ten SHALL follow the same rules as sec_one and sec_ten; the full range SHALL be 00:00..59:59.
REQ-017 On the count edge 59:59 -> 00:00, total_carry SHALL be 1 for exactly the following cycle; otherwise it SHALL be 0.
REQ-018 IDLE: start=1 and pause=0 -> RUN; otherwise stay in IDLE.
REQ-019 RUN: pause=1 -> PAUSE, with no count on that edge; a count edge whose incremented value equals the limit -> DONE, with the new value stored.
REQ-020 PAUSE: start=1 and pause=0 -> RUN, with no count on that edge; otherwise stay in PAUSE.
REQ-021 DONE: digits SHALL hold and increase SHALL be ignored; start=1 SHALL reload the init values and go to RUN; pause SHALL be ignored.
REQ-022 Priority: pause SHALL override start in IDLE, RUN and PAUSE.
REQ-023 The limit SHALL be compared only against the post-increment value; a count that already equals the limit when RUN is entered SHALL NOT end the run until it is reached again by counting.
REQ-024 Limit 00:00 SHALL be reached by wrap; on that edge total_carry and the transition to DONE SHALL both occur.
REQ-025 done SHALL be asserted in the cycle after the edge that enters DONE and SHALL deassert in the cycle after leaving DONE.
REQ-026 Limit and init inputs SHALL be sampled live; a limit change during RUN SHALL apply from the next count edge.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, done=0 and total_carry=0, and load each digit from its init input, independent of clk.
REQ-028 reset asserted mid-run SHALL abandon the run; after release the block SHALL wait in IDLE for start.
REQ-029 The first rising edge after reset release SHALL behave as a normal IDLE edge.

Verification
REQ-030 init 00:00, limit 00:05, start pulse, then 5 increase ticks -> 00:05, state=3 and done=1 after the 5th tick; further ticks leave 00:05.
REQ-031 init 59:58, limit 00:10, run and 2 ticks -> 59:59, then 00:00 with total_carry=1 for one cycle and state=RUN.
REQ-032 init 00:09, RUN, increase held high with pause=1 for 3 cycles -> state=PAUSE and count 00:09; then start=1 -> RUN; one tick -> 00:10.
REQ-033 In DONE at 00:05 with init 01:00, start=1 -> count 01:00 next cycle, state=RUN, done=0.
REQ-034 In RUN at 12:34, reset low between clock edges -> outputs equal init and state=IDLE before the next edge.
REQ-035 Limit 00:00 with init 59:59, one tick -> 00:00, total_carry=1 and state=DONE on the same edge.
